// File: rtl/div_issue_collect.sv
// Valid/ready wrapper around the fixed-latency FP32 divider: credit-gated issue,
// a tag/flag delay line that tracks in-flight ops, and an FWFT result FIFO.
module div_issue_collect #(
  parameter int DIV_LATENCY = 36,
  parameter int TAG_W       = 8,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 32 + TAG_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      push_y;

  // Delay line: stage DIV_LATENCY lines up with the quotient on div_y.
  logic [DIV_LATENCY:0] dl_valid;
  logic [DIV_LATENCY:0] dl_dz;
  logic [DIV_LATENCY:0] dl_sx;
  logic [DIV_LATENCY:0] dl_az;
  logic [TAG_W-1:0]     dl_tag [DIV_LATENCY+1];

  logic [ENT_W-1:0] mem [FIFO_DEPTH];

  // Credits depend on registers only, so in_ready has no combinational input path.
  assign in_ready  = (outstanding < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = dl_valid[DIV_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_a       <= '0;
      div_b       <= '0;
      dl_valid[0] <= 1'b0;
    end else begin
      dl_valid[0] <= accept;
      if (accept) begin
        div_a <= in_a;
        div_b <= in_b;
      end
    end
    dl_tag[0] <= in_tag;
    dl_dz[0]  <= (in_b[30:0] == 31'd0);
    dl_sx[0]  <= in_a[31] ^ in_b[31];
    dl_az[0]  <= (in_a[30:0] == 31'd0);
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i <= DIV_LATENCY; i++) begin
      dl_tag[i] <= dl_tag[i-1];
      dl_dz[i]  <= dl_dz[i-1];
      dl_sx[i]  <= dl_sx[i-1];
      dl_az[i]  <= dl_az[i-1];
    end
    if (rst) begin
      dl_valid[DIV_LATENCY:1] <= '0;
    end else begin
      dl_valid[DIV_LATENCY:1] <= dl_valid[DIV_LATENCY-1:0];
    end
  end

  // Zero divisors bypass whatever the divider produced.
  always_comb begin
    push_y = div_y;
    if (dl_dz[DIV_LATENCY]) begin
      push_y = dl_az[DIV_LATENCY] ? 32'h7FC0_0000 : {dl_sx[DIV_LATENCY], 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_y, dl_tag[DIV_LATENCY], dl_dz[DIV_LATENCY]};
    end
  end

  assign {out_y, out_tag, out_dz} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
